// File: rtl/lbist_misr_ctrl_if.sv
// Control and data bundle between the LBIST sequencer/CUT side and the MISR compaction stage.
// master drives the run controls and responses; slave is the compaction stage.
interface lbist_misr_ctrl_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
);
    logic             start;
    logic             resp_valid;
    logic [WIDTH-1:0] resp_in;
    logic [WIDTH-1:0] golden;
    logic             busy;
    logic             done;
    logic             pass;
    logic [WIDTH-1:0] signature;
    logic [CNT_W-1:0] count;

    modport master (
        output start, resp_valid, resp_in, golden,
        input  busy, done, pass, signature, count
    );

    modport slave (
        input  start, resp_valid, resp_in, golden,
        output busy, done, pass, signature, count
    );
endinterface

// File: rtl/lbist_misr_ctrl.sv
// LBIST response compaction: folds PATTERN_COUNT CUT responses into a MISR,
// then compares the final signature against a golden value.
module lbist_misr_ctrl #(
    parameter int unsigned      WIDTH         = 8,
    parameter logic [WIDTH-1:0] POLY          = WIDTH'(8'hB8),
    parameter logic [WIDTH-1:0] SEED          = '0,
    parameter int unsigned      CNT_W         = 8,
    parameter int unsigned      PATTERN_COUNT = 255
) (
    input  logic               clk,
    input  logic               reset,
    lbist_misr_ctrl_if.slave   bus
);

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(PATTERN_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPACT = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             start_ok;
    logic             fb;

    // State and datapath registers; reset aborts any run with no result reported
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    // Next-state, MISR update and registered-output next values
    always_comb begin
        state_d  = state_q;
        sig_d    = sig_q;
        cnt_d    = cnt_q;
        pass_d   = pass_q;
        start_ok = 1'b0;
        fb       = ^(sig_q & POLY);

        case (state_q)
            IDLE, DONE: begin
                // start outranks a coincident response, which is dropped
                if (bus.start) begin
                    start_ok = 1'b1;
                    sig_d    = SEED;
                    cnt_d    = '0;
                    pass_d   = 1'b0;
                    state_d  = COMPACT;
                end
            end
            COMPACT: begin
                if (bus.resp_valid) begin
                    sig_d = {sig_q[WIDTH-2:0], fb} ^ bus.resp_in;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == TERM_CNT) begin
                        state_d = COMPARE;
                    end
                end
            end
            COMPARE: begin
                pass_d  = (sig_q == bus.golden);
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flags trail the state by one edge so done rises two edges after the last response
        busy_d = start_ok || (state_q == COMPACT) || (state_q == COMPARE);
        done_d = (state_q == DONE) && !start_ok;
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.signature = sig_q;
    assign bus.count     = cnt_q;

endmodule

// File: tb/tb_lbist_misr_ctrl.sv
// Self-checking bench for lbist_misr_ctrl: three instances cover the pass/fail,
// feedback and gap/restart scenarios, with a per-edge scoreboard of signature/count.
module tb_lbist_misr_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lbist_misr_ctrl_if #(.WIDTH(8), .CNT_W(8)) a_if ();
    lbist_misr_ctrl_if #(.WIDTH(8), .CNT_W(8)) b_if ();
    lbist_misr_ctrl_if #(.WIDTH(8), .CNT_W(8)) c_if ();

    lbist_misr_ctrl #(.WIDTH(8), .POLY(8'hB8), .SEED(8'h00), .CNT_W(8), .PATTERN_COUNT(2))
        u_a (.clk(clk), .reset(reset), .bus(a_if.slave));
    lbist_misr_ctrl #(.WIDTH(8), .POLY(8'hB8), .SEED(8'h80), .CNT_W(8), .PATTERN_COUNT(2))
        u_b (.clk(clk), .reset(reset), .bus(b_if.slave));
    lbist_misr_ctrl #(.WIDTH(8), .POLY(8'hB8), .SEED(8'h00), .CNT_W(8), .PATTERN_COUNT(3))
        u_c (.clk(clk), .reset(reset), .bus(c_if.slave));

    typedef struct packed {
        logic [7:0] sig;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    string      tname  = "reset";
    logic [7:0] gold   = 8'h00;

    int         m_st  [3];
    logic [7:0] m_sig [3];
    logic [7:0] m_cnt [3];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s/%s got %0h expected %0h", tname, tag, got, exp);
        end
    endtask

    function automatic logic [7:0] seed_of(int s);
        return (s == 1) ? 8'h80 : 8'h00;
    endfunction

    function automatic int pc_of(int s);
        return (s == 2) ? 3 : 2;
    endfunction

    function automatic logic [7:0] misr_step(logic [7:0] sig, logic [7:0] resp);
        logic [7:0] taps;
        taps = sig & 8'hB8;
        return {sig[6:0], ^taps} ^ resp;
    endfunction

    function automatic logic [7:0] sig_of(int s);
        case (s)
            0:       return a_if.signature;
            1:       return b_if.signature;
            default: return c_if.signature;
        endcase
    endfunction

    function automatic logic [7:0] cnt_of(int s);
        case (s)
            0:       return a_if.count;
            1:       return b_if.count;
            default: return c_if.count;
        endcase
    endfunction

    // {busy, done, pass}
    function automatic logic [2:0] flags_of(int s);
        case (s)
            0:       return {a_if.busy, a_if.done, a_if.pass};
            1:       return {b_if.busy, b_if.done, b_if.pass};
            default: return {c_if.busy, c_if.done, c_if.pass};
        endcase
    endfunction

    task automatic set_inputs(int s, logic st, logic v, logic [7:0] d);
        a_if.start = 1'b0; a_if.resp_valid = 1'b0; a_if.resp_in = 8'h00; a_if.golden = gold;
        b_if.start = 1'b0; b_if.resp_valid = 1'b0; b_if.resp_in = 8'h00; b_if.golden = gold;
        c_if.start = 1'b0; c_if.resp_valid = 1'b0; c_if.resp_in = 8'h00; c_if.golden = gold;
        case (s)
            0:       begin a_if.start = st; a_if.resp_valid = v; a_if.resp_in = d; end
            1:       begin b_if.start = st; b_if.resp_valid = v; b_if.resp_in = d; end
            default: begin c_if.start = st; c_if.resp_valid = v; c_if.resp_in = d; end
        endcase
    endtask

    task automatic model_reset();
        for (int s = 0; s < 3; s++) begin
            m_st[s]  = 0;
            m_sig[s] = seed_of(s);
            m_cnt[s] = 8'h00;
        end
    endtask

    // Drive one cycle, push the model's expectation, then compare after the edge
    task automatic drive(int s, logic st, logic v, logic [7:0] d);
        exp_t e;
        set_inputs(s, st, v, d);
        case (m_st[s])
            0, 3: if (st) begin
                m_sig[s] = seed_of(s);
                m_cnt[s] = 8'h00;
                m_st[s]  = 1;
            end
            1: if (v) begin
                m_sig[s] = misr_step(m_sig[s], d);
                m_cnt[s] = m_cnt[s] + 8'h01;
                if (int'(m_cnt[s]) == pc_of(s)) m_st[s] = 2;
            end
            default: m_st[s] = 3;
        endcase
        sb_q.push_back('{sig: m_sig[s], cnt: m_cnt[s]});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("sig", 32'(sig_of(s)), 32'(e.sig));
        check("cnt", 32'(cnt_of(s)), 32'(e.cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        set_inputs(0, 1'b0, 1'b0, 8'h00);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            check("rst_sig", 32'(sig_of(s)), 32'(seed_of(s)));
            check("rst_cnt", 32'(cnt_of(s)), 32'h0);
            check("rst_flags", 32'(flags_of(s)), 32'b000);
        end
        reset = 1'b1;

        tname = "basic_pass"; gold = 8'h82;
        drive(0, 1'b1, 1'b0, 8'h00);
        check("flags_start", 32'(flags_of(0)), 32'b100);
        drive(0, 1'b0, 1'b1, 8'h01);
        drive(0, 1'b0, 1'b1, 8'h80);
        drive(0, 1'b0, 1'b0, 8'h00);
        check("busy_n1", 32'(flags_of(0) >> 1), 32'b10);
        drive(0, 1'b0, 1'b0, 8'h00);
        check("flags_n2", 32'(flags_of(0)), 32'b011);
        drive(0, 1'b0, 1'b0, 8'h00);
        check("flags_hold", 32'(flags_of(0)), 32'b011);

        tname = "fail_detect"; gold = 8'h83;
        drive(0, 1'b1, 1'b0, 8'h00);
        check("flags_restart", 32'(flags_of(0)), 32'b100);
        drive(0, 1'b0, 1'b1, 8'h01);
        drive(0, 1'b0, 1'b1, 8'h80);
        drive(0, 1'b0, 1'b0, 8'h00);
        drive(0, 1'b0, 1'b0, 8'h00);
        check("flags_n2", 32'(flags_of(0)), 32'b010);
        check("final_sig", 32'(sig_of(0)), 32'h82);

        tname = "feedback"; gold = 8'h02;
        drive(1, 1'b1, 1'b0, 8'h00);
        drive(1, 1'b0, 1'b1, 8'h00);
        check("sig_first", 32'(sig_of(1)), 32'h01);
        drive(1, 1'b0, 1'b1, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00);
        check("flags_n2", 32'(flags_of(1)), 32'b011);

        tname = "gaps"; gold = 8'h04;
        drive(2, 1'b1, 1'b0, 8'h00);
        drive(2, 1'b0, 1'b1, 8'h01);
        drive(2, 1'b0, 1'b0, 8'hFF);
        drive(2, 1'b1, 1'b0, 8'hFF);
        check("flags_midstart", 32'(flags_of(2) >> 1), 32'b10);
        drive(2, 1'b0, 1'b1, 8'h00);
        drive(2, 1'b0, 1'b0, 8'hFF);
        drive(2, 1'b0, 1'b1, 8'h00);
        check("sig_last", 32'(sig_of(2)), 32'h04);
        drive(2, 1'b0, 1'b1, 8'hFF);
        check("busy_n1", 32'(flags_of(2) >> 1), 32'b10);
        drive(2, 1'b0, 1'b1, 8'hFF);
        check("flags_n2", 32'(flags_of(2)), 32'b011);
        check("cnt_final", 32'(cnt_of(2)), 32'h3);

        tname = "restart_simul";
        drive(2, 1'b1, 1'b1, 8'hFF);
        check("flags", 32'(flags_of(2)), 32'b100);

        tname = "reset_mid";
        drive(2, 1'b0, 1'b1, 8'h01);
        reset = 1'b0;
        #2;
        model_reset();
        check("sig", 32'(sig_of(2)), 32'h00);
        check("cnt", 32'(cnt_of(2)), 32'h0);
        check("flags", 32'(flags_of(2)), 32'b000);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(2, 1'b0, 1'b1, 8'h55);
        check("idle_flags", 32'(flags_of(2)), 32'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
